rs_decoder_10_8: RTL and testbench
==================================

RS_DECODER_10_8 -- requirements
Module: rs_decoder_10_8

Interface
REQ-001 Parameter SYMBOL_WIDTH, default 4: GF(16) symbol width; the block SHALL support only 4.
REQ-002 Parameter N, default 10: codeword length in symbols; the block SHALL support only 10.
REQ-003 Parameter K, default 8: data symbols per codeword; the block SHALL support only 8.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  4  received symbol, polynomial basis, bit3 = alpha^0 coefficient, bit0 = alpha^3 coefficient.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_data  output  4  corrected data symbol, same basis as in_data.
REQ-010 out_valid  output  1  out_data and the status outputs are valid.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_last  output  1  high on the 8th (final) data beat.
REQ-013 err_corrected  output  1  one symbol error was found and corrected, or was in parity.
REQ-014 err_uncorrectable  output  1  syndrome pattern is not a single error; data is passed through unmodified.

Function
REQ-015 Field: GF(16) with primitive polynomial x^4+x+1 and alpha = 0100; code roots SHALL be alpha^1 and alpha^2.
REQ-016 Symbol order: the first symbol accepted SHALL be the degree-9 coefficient and the 10th SHALL be degree 0; degrees 9..2 are data and 1..0 are parity.
REQ-017 Transfer rules: a beat SHALL transfer when valid and ready are both high; out_data, out_valid, out_last and the flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 FSM states SHALL be COLLECT, SOLVE and EMIT.
REQ-019 COLLECT: in_ready=1; each accepted symbol SHALL be stored and folded in by Horner, S1 <= S1*alpha ^ r and S2 <= S2*alpha^2 ^ r.
REQ-020 COLLECT: a symbol counter SHALL run 0..9, and the 10th accept SHALL move the FSM to SOLVE and clear the counter.
REQ-021 SOLVE lasts exactly one cycle with in_ready=0 and out_valid=0.
REQ-022 SOLVE decision: if S1=0 and S2=0, no error and no flag.
REQ-023 SOLVE decision: if exactly one of S1, S2 is 0, set err_uncorrectable.
REQ-024 SOLVE decision: otherwise p = (log S2 - log S1) mod 15; if p >= 10, set err_uncorrectable.
REQ-025 SOLVE decision: otherwise error value e = alpha^((2*log S1 - log S2) mod 15), and set err_corrected.
REQ-026 Correction: if err_corrected and 2 <= p <= 9, the stored data symbol at degree p SHALL be XORed with e on output; if p is 0 or 1, data SHALL pass unmodified.
REQ-027 EMIT: in_ready=0; the block SHALL present the 8 data symbols, degree 9 first, one per accepted beat, with out_last on the 8th; the flags SHALL be constant for all 8 beats.
REQ-028 EMIT exit: acceptance of the out_last beat SHALL return the FSM to COLLECT with S1=S2=0, and in_ready SHALL be 1 on the next cycle.
REQ-029 Latency: if the 10th symbol is accepted in cycle T, the first out_valid SHALL be in cycle T+2.
REQ-030 Throughput: input SHALL not overlap output; minimum period is 10+1+8 = 19 cycles per codeword.
REQ-031 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-032 While reset=1 the block SHALL go to COLLECT and clear S1, S2, the counter and the flags.
REQ-033 While reset=1 the outputs SHALL be in_ready=0, out_valid=0, out_last=0, out_data=0000, err_corrected=0, err_uncorrectable=0; in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-034 Reset asserted mid-COLLECT or mid-EMIT SHALL discard the partial codeword, and no further output beats SHALL appear.

Verification
REQ-035 Ten symbols of 0000, out_ready=1 -> 8 beats of 0000, flags 0, first out_valid 2 cycles after the 10th accept, out_last on beat 8.
REQ-036 Symbol 1 = 1000, rest 0000 -> S1 = alpha^9, S2 = alpha^3, p = 9, e = 1000; 8 beats of 0000, err_corrected=1.
REQ-037 Symbols 1 and 2 = 1000, rest 0000 -> S1 = 1111, S2 = 0101, p = 12; err_uncorrectable=1, output 1000,1000,0000 x6 unmodified.
REQ-038 Error only in the 10th symbol (0110) of an all-zero word -> err_corrected=1, 8 beats of 0000.
REQ-039 out_ready toggling 1/0 during EMIT -> each beat held stable until accepted, exactly 8 beats, in_ready=0 until out_last is accepted.
REQ-040 Reset pulsed after 5 input symbols, then a clean all-zero word -> no output from the aborted word; the clean word decodes per REQ-035.

Source files
------------

// File: rtl/rs_decoder_10_8.sv
// RS(10,8) single-symbol-error decoder over GF(16) (x^4+x+1), roots alpha^1 and alpha^2.
// Buffers one codeword, solves it in a single cycle, then streams the 8 corrected data symbols.
module rs_decoder_10_8 #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int N            = 10,
    parameter int K            = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SYMBOL_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    err_corrected,
    output logic                    err_uncorrectable
);

    typedef enum logic [1:0] {COLLECT, SOLVE, EMIT} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic [2:0] idx_next;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] mem [0:7];
    logic       fix;
    logic [3:0] fix_deg;
    logic [3:0] fix_val;

    logic [3:0] l1;
    logic [3:0] l2;
    logic [3:0] p;
    logic [3:0] e_exp;
    logic       dec_fix;
    logic       dec_unc;
    logic [3:0] dec_deg;
    logic [3:0] dec_val;

    // Port symbols put alpha^0 in bit3; internal arithmetic uses bit i = alpha^i.
    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [3:0] mul_a(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] gf_log(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'b0001: r = 4'd0;
            4'b0010: r = 4'd1;
            4'b0100: r = 4'd2;
            4'b1000: r = 4'd3;
            4'b0011: r = 4'd4;
            4'b0110: r = 4'd5;
            4'b1100: r = 4'd6;
            4'b1011: r = 4'd7;
            4'b0101: r = 4'd8;
            4'b1010: r = 4'd9;
            4'b0111: r = 4'd10;
            4'b1110: r = 4'd11;
            4'b1111: r = 4'd12;
            4'b1101: r = 4'd13;
            4'b1001: r = 4'd14;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] gf_exp(input logic [3:0] k);
        logic [3:0] r;
        case (k)
            4'd0:    r = 4'b0001;
            4'd1:    r = 4'b0010;
            4'd2:    r = 4'b0100;
            4'd3:    r = 4'b1000;
            4'd4:    r = 4'b0011;
            4'd5:    r = 4'b0110;
            4'd6:    r = 4'b1100;
            4'd7:    r = 4'b1011;
            4'd8:    r = 4'b0101;
            4'd9:    r = 4'b1010;
            4'd10:   r = 4'b0111;
            4'd11:   r = 4'b1110;
            4'd12:   r = 4'b1111;
            4'd13:   r = 4'b1101;
            4'd14:   r = 4'b1001;
            default: r = 4'b0001;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] mod15(input logic [5:0] v);
        logic [5:0] r;
        r = v;
        if (r >= 6'd30) begin
            r = r - 6'd30;
        end else if (r >= 6'd15) begin
            r = r - 6'd15;
        end
        return r[3:0];
    endfunction

    // Buffer index i holds degree 9-i, so parity positions (p = 0, 1) never match.
    function automatic logic [3:0] corrected(input logic [3:0] sym, input logic [2:0] i,
                                             input logic f, input logic [3:0] deg,
                                             input logic [3:0] val);
        return sym ^ ((f && (deg == 4'd9 - {1'b0, i})) ? val : 4'b0000);
    endfunction

    assign l1       = gf_log(s1);
    assign l2       = gf_log(s2);
    assign p        = mod15(6'd15 + {2'b00, l2} - {2'b00, l1});
    assign e_exp    = mod15(6'd15 + {1'b0, l1, 1'b0} - {2'b00, l2});
    assign idx_next = idx + 3'd1;

    always_comb begin
        dec_fix = 1'b0;
        dec_unc = 1'b0;
        dec_deg = 4'd0;
        dec_val = 4'd0;
        if (s1 == 4'd0 && s2 == 4'd0) begin
            dec_fix = 1'b0;
        end else if (s1 == 4'd0 || s2 == 4'd0) begin
            dec_unc = 1'b1;
        end else if (p >= 4'd10) begin
            dec_unc = 1'b1;
        end else begin
            dec_fix = 1'b1;
            dec_deg = p;
            dec_val = rev4(gf_exp(e_exp));
        end
    end

    // Ready is decoded from state so it rises in the very first cycle after reset.
    assign in_ready = (state == COLLECT) && !reset;

    always_ff @(posedge clk) begin
        if (state == COLLECT && in_valid && cnt < 4'(K)) begin
            mem[cnt[2:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= COLLECT;
            cnt               <= 4'd0;
            idx               <= 3'd0;
            s1                <= 4'd0;
            s2                <= 4'd0;
            fix               <= 1'b0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_data          <= 4'd0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        s1 <= mul_a(s1) ^ rev4(in_data);
                        s2 <= mul_a(mul_a(s2)) ^ rev4(in_data);
                        if (cnt == 4'(N - 1)) begin
                            cnt   <= 4'd0;
                            state <= SOLVE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                SOLVE: begin
                    fix               <= dec_fix;
                    fix_deg           <= dec_deg;
                    fix_val           <= dec_val;
                    err_corrected     <= dec_fix;
                    err_uncorrectable <= dec_unc;
                    idx               <= 3'd0;
                    out_data          <= corrected(mem[0], 3'd0, dec_fix, dec_deg, dec_val);
                    out_valid         <= 1'b1;
                    out_last          <= 1'b0;
                    state             <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            s1        <= 4'd0;
                            s2        <= 4'd0;
                            state     <= COLLECT;
                        end else begin
                            idx      <= idx_next;
                            out_data <= corrected(mem[idx_next], idx_next, fix, fix_deg, fix_val);
                            out_last <= (idx_next == 3'(K - 1));
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_decoder_10_8.sv
// Bench for rs_decoder_10_8: directed words plus random codewords with 0, 1 or 2 symbol errors.
module tb_rs_decoder_10_8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_data = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       err_corrected;
    logic       err_uncorrectable;

    int checks = 0;
    int miscompares = 0;
    int cyc = 0;
    int pw[15];
    int lg[16];

    typedef logic [3:0] word_t [10];
    typedef logic [3:0] data_t [8];

    rs_decoder_10_8 dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .err_corrected(err_corrected),
        .err_uncorrectable(err_uncorrectable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rev(input logic [3:0] x);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = x[3-b];
        return r;
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return pw[(lg[a] + lg[b]) % 15];
    endfunction

    // Syndrome as a direct polynomial evaluation r(alpha^j), first symbol = degree 9.
    function automatic int syn(input word_t w, input int j);
        int s = 0;
        for (int k = 0; k < 10; k++) s ^= gmul(int'(rev(w[k])), pw[((9 - k) * j) % 15]);
        return s;
    endfunction

    task automatic model(input word_t w, output data_t o, output logic c, output logic u);
        int s1, s2, p, ev;
        s1 = syn(w, 1);
        s2 = syn(w, 2);
        c = 1'b0; u = 1'b0; p = -1; ev = 0;
        if (s1 == 0 && s2 == 0) begin
            p = -1;
        end else if (s1 == 0 || s2 == 0) begin
            u = 1'b1;
        end else begin
            p = (lg[s2] - lg[s1] + 15) % 15;
            if (p >= 10) begin
                u = 1'b1;
                p = -1;
            end else begin
                c = 1'b1;
                ev = pw[(((2 * lg[s1] - lg[s2]) % 15) + 15) % 15];
            end
        end
        for (int i = 0; i < 8; i++) o[i] = w[i] ^ ((c && p == 9 - i) ? rev(4'(ev)) : 4'd0);
    endtask

    task automatic send(input word_t w, input int n, input int gaps, output int t_last);
        int k = 0;
        int budget = 0;
        t_last = -1;
        while (k < n && budget < 200) begin
            logic acc;
            if (gaps != 0 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = w[k];
            end
            acc = in_valid && in_ready;
            tick();
            budget++;
            if (acc) begin
                k++;
                if (k == n) t_last = cyc;
            end
        end
        in_valid = 1'b0;
        chk("send_accepted", k, n);
    endtask

    task automatic recv(input data_t ed, input logic ec, input logic eu, input int mode,
                        input int t10, input int max_beats);
        int beats = 0;
        int budget = 0;
        int first = -1;
        logic held = 1'b0;
        logic [3:0] hd = 4'd0;
        logic hl = 1'b0;
        while (beats < max_beats && budget < 300) begin
            logic rdy;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = budget[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            chk("in_ready_busy", in_ready, 0);
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_last", out_last, hl);
            end
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (t10 >= 0) chk("latency", first - t10, 1);
                end
                if (rdy) begin
                    chk("beat_data", out_data, ed[beats]);
                    chk("beat_last", out_last, (beats == 7) ? 1 : 0);
                    chk("beat_corr", err_corrected, ec);
                    chk("beat_unc", err_uncorrectable, eu);
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = out_data;
                    hl = out_last;
                end
            end else begin
                held = 1'b0;
            end
            tick();
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("recv_beats", beats, max_beats);
        if (max_beats == 8) begin
            chk("done_valid", out_valid, 0);
            chk("done_ready", in_ready, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_corr"}, err_corrected, 0);
        chk({tag, "_unc"}, err_uncorrectable, 0);
    endtask

    task automatic watch_silent(input string tag);
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick();
        end
        out_ready = 1'b0;
        chk(tag, seen, 0);
    endtask

    initial begin
        word_t w, cw;
        data_t ez, ed, e37;
        logic  mc, mu;
        int    t, emode, pos, pos2, found;

        pw[0] = 1;
        for (int i = 1; i < 15; i++) begin
            int v;
            v = pw[i-1] << 1;
            if ((v & 16) != 0) v ^= 19;
            pw[i] = v;
        end
        lg[0] = 0;
        for (int i = 0; i < 15; i++) lg[pw[i]] = i;
        for (int i = 0; i < 8; i++) ez[i] = 4'd0;
        e37 = ez;
        e37[0] = 4'b1000;
        e37[1] = 4'b1000;

        reset = 1'b1;
        tick(); tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);
        tick();

        // All-zero word
        for (int i = 0; i < 10; i++) w[i] = 4'd0;
        send(w, 10, 0, t);
        recv(ez, 1'b0, 1'b0, 0, t, 8);

        // Single error in the first (degree 9) symbol
        w[0] = 4'b1000;
        send(w, 10, 0, t);
        recv(ez, 1'b1, 1'b0, 0, t, 8);

        // Two errors: uncorrectable, passed through
        w[1] = 4'b1000;
        send(w, 10, 0, t);
        recv(e37, 1'b0, 1'b1, 0, t, 8);

        // Error in the last parity symbol
        for (int i = 0; i < 10; i++) w[i] = 4'd0;
        w[9] = 4'b0110;
        send(w, 10, 0, t);
        recv(ez, 1'b1, 1'b0, 0, t, 8);

        // Mid-word data error with out_ready toggling
        for (int i = 0; i < 10; i++) w[i] = 4'd0;
        w[4] = 4'b0011;
        send(w, 10, 0, t);
        recv(ez, 1'b1, 1'b0, 1, t, 8);

        // Reset after 5 symbols, then a clean word
        for (int i = 0; i < 10; i++) w[i] = 4'd0;
        w[2] = 4'b0101;
        send(w, 5, 0, t);
        reset = 1'b1;
        tick(); tick();
        check_reset_outputs("abort_collect");
        reset = 1'b0;
        watch_silent("abort_collect_silent");
        for (int i = 0; i < 10; i++) w[i] = 4'd0;
        send(w, 10, 0, t);
        recv(ez, 1'b0, 1'b0, 0, t, 8);

        // Reset after 3 output beats
        w[0] = 4'b1000;
        w[1] = 4'b1000;
        send(w, 10, 0, t);
        recv(e37, 1'b0, 1'b1, 0, t, 3);
        reset = 1'b1;
        tick(); tick();
        check_reset_outputs("abort_emit");
        reset = 1'b0;
        watch_silent("abort_emit_silent");

        // Random codewords with 0, 1 or 2 injected symbol errors
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 8; i++) cw[i] = 4'($urandom);
            found = 0;
            for (int a = 0; a < 16 && found == 0; a++) begin
                for (int b = 0; b < 16 && found == 0; b++) begin
                    cw[8] = 4'(a);
                    cw[9] = 4'(b);
                    if (syn(cw, 1) == 0 && syn(cw, 2) == 0) found = 1;
                end
            end
            chk("encode_found", found, 1);
            w = cw;
            emode = $urandom_range(0, 2);
            pos = $urandom_range(0, 9);
            if (emode >= 1) w[pos] = w[pos] ^ 4'($urandom_range(1, 15));
            if (emode == 2) begin
                pos2 = (pos + $urandom_range(1, 9)) % 10;
                w[pos2] = w[pos2] ^ 4'($urandom_range(1, 15));
            end
            for (int i = 0; i < 8; i++) ed[i] = cw[i];
            mc = (emode == 1);
            mu = 1'b0;
            if (emode == 2) model(w, ed, mc, mu);
            send(w, 10, $urandom_range(0, 1), t);
            recv(ed, mc, mu, $urandom_range(0, 2), t, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
